seq_mult_param: RTL and testbench

- Parametrised radix-2 sequential shift-add multiplier with a per-operation signed/unsigned mode select.
- Replaces the fixed 8x8 unsigned multiplier used by the VGA datapath, for example for pixel-address arithmetic (row*stride) and colour scaling.
- Uses a start/busy/done handshake with fixed latency, and holds the product stable until the next operation completes.

---
 rtl/seq_mult_param_if.sv | 12 +
 rtl/seq_mult_param.sv | 79 +++++++
 tb/tb_seq_mult_param.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: start/busy/done handshake and operand/product bus for seq_mult_param
interface seq_mult_param_if #(parameter int WIDTH = 8);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic [2*WIDTH-1:0] out;
    logic               busy;
    logic               done;
    modport master (output start, signed_mode, in1, in2, input out, busy, done);
    modport slave (input start, signed_mode, in1, in2, output out, busy, done);
endinterface

// File: rtl/seq_mult_param.sv
// seq_mult_param: radix-2 shift-add multiplier, signed/unsigned per operation, fixed WIDTH+2 latency
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            reset,
    seq_mult_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, out_q, out_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d, mag1, mag2;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d, busy_q, busy_d, done_q, done_d;
    // Operands are multiplied as magnitudes; the sign is reapplied once at the end
    assign mag1 = (bus.signed_mode & bus.in1[WIDTH-1]) ? ~bus.in1 + 1'b1 : bus.in1;
    assign mag2 = (bus.signed_mode & bus.in2[WIDTH-1]) ? ~bus.in2 + 1'b1 : bus.in2;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        out_d    = out_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = RUN;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, mag1};
                mplier_d = mag2;
                neg_d    = bus.signed_mode & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                cnt_d    = CNT_W'(WIDTH);
            end
            RUN: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                state_d  = (cnt_q == CNT_W'(1)) ? FINISH : RUN;
            end
            FINISH: begin
                out_d   = neg_q ? ~acc_q + 1'b1 : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed scoreboard bench for 8- and 16-bit instances of seq_mult_param
module tb_seq_mult_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];
    always #5 clk = ~clk;
    seq_mult_param_if #(.WIDTH(8)) b8();
    seq_mult_param_if #(.WIDTH(16)) b16();
    seq_mult_param #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8));
    seq_mult_param #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(b16));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] model(input bit wide, input bit sm, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb_v, p;
        if (wide) begin
            sa   = sm ? {{16{a[15]}}, a} : {16'b0, a};
            sb_v = sm ? {{16{b[15]}}, b} : {16'b0, b};
            p = sa * sb_v;
            return p;
        end
        sa   = sm ? {{24{a[7]}}, a[7:0]} : {24'b0, a[7:0]};
        sb_v = sm ? {{24{b[7]}}, b[7:0]} : {24'b0, b[7:0]};
        p = sa * sb_v;
        return {16'b0, p[15:0]};
    endfunction
    task automatic drive(input bit wide, input bit sm, input logic [15:0] a, input logic [15:0] b, input bit go);
        if (wide) begin
            b16.start = go; b16.signed_mode = sm; b16.in1 = a; b16.in2 = b;
        end else begin
            b8.start = go; b8.signed_mode = sm; b8.in1 = a[7:0]; b8.in2 = b[7:0];
        end
    endtask
    task automatic get(input bit wide, output logic [31:0] o, output logic bz, output logic dn);
        o  = wide ? b16.out : {16'b0, b8.out};
        bz = wide ? b16.busy : b8.busy;
        dn = wide ? b16.done : b8.done;
    endtask
    // Called at the negedge of cycle 0; returns at the negedge of the done cycle
    task automatic run_op(input bit wide, input bit sm, input logic [15:0] a, input logic [15:0] b, input bit poke);
        int w;
        logic [31:0] prev, o;
        logic bz, dn;
        w = wide ? 16 : 8;
        get(wide, prev, bz, dn);
        sb.push_back(model(wide, sm, a, b));
        drive(wide, sm, a, b, 1'b1);
        for (int c = 1; c <= w + 2; c++) begin
            @(negedge clk);
            get(wide, o, bz, dn);
            if (c == 1) drive(wide, sm, a, b, 1'b0);
            if (c == 2) drive(wide, ~sm, ~a, b ^ 16'h5a5a, 1'b0);
            if (poke && c == 4) drive(wide, ~sm, ~a, b ^ 16'h5a5a, 1'b1);
            if (poke && c == 5) drive(wide, ~sm, ~a, b ^ 16'h5a5a, 1'b0);
            chk("busy", {31'b0, bz}, {31'b0, c <= w + 1});
            chk("done", {31'b0, dn}, {31'b0, c == w + 2});
            if (c <= w + 1) chk("out_hold", o, prev);
            else chk("product", o, sb.pop_front());
        end
    endtask
    initial begin
        logic [31:0] o;
        logic bz, dn;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        get(1'b0, o, bz, dn);
        chk("rst_out8", o, 32'h0);
        chk("rst_busy8", {31'b0, bz}, 32'h0);
        chk("rst_done8", {31'b0, dn}, 32'h0);
        get(1'b1, o, bz, dn);
        chk("rst_out16", o, 32'h0);
        chk("rst_busy16", {31'b0, bz}, 32'h0);
        repeat (20) @(negedge clk);
        get(1'b0, o, bz, dn);
        chk("idle_out", o, 32'h0);
        chk("idle_busy", {31'b0, bz}, 32'h0);
        chk("idle_done", {31'b0, dn}, 32'h0);
        run_op(1'b0, 1'b0, 16'hFF, 16'hFF, 1'b0);
        @(negedge clk);
        run_op(1'b0, 1'b0, 16'h80, 16'h7F, 1'b0);
        run_op(1'b0, 1'b1, 16'h80, 16'h7F, 1'b0);
        run_op(1'b0, 1'b1, 16'h80, 16'h80, 1'b0);
        run_op(1'b0, 1'b1, 16'hFF, 16'h01, 1'b0);
        run_op(1'b0, 1'b1, 16'h00, 16'h80, 1'b0);
        @(negedge clk);
        run_op(1'b0, 1'b0, 16'h03, 16'h05, 1'b0);
        run_op(1'b0, 1'b0, 16'h07, 16'h09, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'hFF, 16'hFF, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) drive(1'b0, 1'b0, 16'hFF, 16'hFF, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        get(1'b0, o, bz, dn);
        chk("abort_out", o, 32'h0);
        chk("abort_busy", {31'b0, bz}, 32'h0);
        chk("abort_done", {31'b0, dn}, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            get(1'b0, o, bz, dn);
            chk("abort_no_done", {31'b0, dn}, 32'h0);
        end
        run_op(1'b0, 1'b0, 16'h02, 16'h03, 1'b0);
        @(negedge clk);
        run_op(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
        run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op(1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
